// File: rtl/fpm_exp_align.sv
// fpm_exp_align: parametrised FPU exponent datapath with a self-timed align/normalise sequencer.
// Optional feature: define FPM_EXP_STICKY_EN to OR shifted-out bits into sticky during ALIGN.
module fpm_exp_align #(
    parameter int EXP_W     = 8,
    parameter int CNT_W     = 6,
    parameter int MANT_BITS = 40
) (
    input  logic             __clk,
    input  logic             _0_f,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [EXP_W-1:0] ea,
    input  logic [EXP_W-1:0] eb,
    input  logic             mant_nz,
    input  logic             mant_norm,
    input  logic             shifted_bit,
    output logic             busy,
    output logic             done,
    output logic             shr_t,
    output logic             shr_c,
    output logic             shl,
    output logic [EXP_W-1:0] e_res,
    output logic [CNT_W-1:0] fic,
    output logic             g,
    output logic             wt,
    output logic             zf,
    output logic             ovf,
    output logic             unf,
    output logic             sticky
);

    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] E_MAX      = XW'(2**(EXP_W-1) - 1);
    localparam logic signed [XW-1:0] E_MIN      = ~E_MAX;
    localparam logic signed [XW-1:0] MANT_X     = XW'(MANT_BITS);
    localparam logic [EXP_W-1:0]     E_RES_MIN  = {1'b1, {(EXP_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]     FIC_LAST_N = CNT_W'(MANT_BITS - 1);

    typedef enum logic [2:0] {IDLE, CALC, ALIGN, NORM, DONE} state_t;

    state_t             state, state_d;
    logic [EXP_W-1:0]   ea_q, eb_q;
    logic [1:0]         op_q;
    logic [EXP_W-1:0]   e_res_d;
    logic [CNT_W-1:0]   fic_d;
    logic               g_d, wt_d, zf_d, ovf_d, unf_d, sticky_d;
    logic               sticky_in;

    logic signed [XW-1:0] ea_x, eb_x, diff, abs_diff, r;

`ifdef FPM_EXP_STICKY_EN
    assign sticky_in = shifted_bit;
`else
    logic unused_shifted_bit;
    assign unused_shifted_bit = shifted_bit;
    assign sticky_in          = 1'b0;
`endif

    // Two guard bits keep every sum/difference of two EXP_W operands exact.
    assign ea_x     = {{2{ea_q[EXP_W-1]}}, ea_q};
    assign eb_x     = {{2{eb_q[EXP_W-1]}}, eb_q};
    assign diff     = ea_x - eb_x;
    assign abs_diff = diff[XW-1] ? -diff : diff;
    assign r        = op_q[1] ? (ea_x - eb_x) : (ea_x + eb_x);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state;
        e_res_d  = e_res;
        fic_d    = fic;
        g_d      = g;
        wt_d     = wt;
        zf_d     = zf;
        ovf_d    = ovf;
        unf_d    = unf;
        sticky_d = sticky;
        busy     = 1'b0;
        done     = 1'b0;
        shr_t    = 1'b0;
        shr_c    = 1'b0;
        shl      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    g_d      = 1'b0;
                    wt_d     = 1'b0;
                    zf_d     = 1'b0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    sticky_d = 1'b0;
                end
            end
            CALC: begin
                busy  = 1'b1;
                fic_d = '0;
                case (op_q)
                    2'b00: begin
                        wt_d    = diff[XW-1];
                        e_res_d = diff[XW-1] ? eb_q : ea_q;
                        if (abs_diff >= MANT_X) begin
                            g_d     = 1'b1;
                            state_d = DONE;
                        end else if (diff == '0) begin
                            state_d = DONE;
                        end else begin
                            fic_d   = CNT_W'(abs_diff);
                            state_d = ALIGN;
                        end
                    end
                    2'b01, 2'b10: begin
                        e_res_d = r[EXP_W-1:0];
                        ovf_d   = (r > E_MAX);
                        unf_d   = (r < E_MIN);
                        state_d = DONE;
                    end
                    default: begin
                        e_res_d = ea_q;
                        state_d = NORM;
                    end
                endcase
            end
            ALIGN: begin
                busy     = 1'b1;
                shr_t    = wt;
                shr_c    = ~wt;
                fic_d    = fic - CNT_W'(1);
                sticky_d = sticky | sticky_in;
                if (fic == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            NORM: begin
                busy = 1'b1;
                if (!mant_nz) begin
                    zf_d    = 1'b1;
                    e_res_d = '0;
                    state_d = DONE;
                end else if (mant_norm) begin
                    state_d = DONE;
                end else if (e_res == E_RES_MIN) begin
                    // One more left shift would push the exponent below its range.
                    unf_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    shl     = 1'b1;
                    e_res_d = e_res - EXP_W'(1);
                    fic_d   = fic + CNT_W'(1);
                    if (fic == FIC_LAST_N) begin
                        zf_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge __clk or posedge _0_f) begin
        if (_0_f) begin
            state  <= IDLE;
            ea_q   <= '0;
            eb_q   <= '0;
            op_q   <= '0;
            e_res  <= '0;
            fic    <= '0;
            g      <= 1'b0;
            wt     <= 1'b0;
            zf     <= 1'b0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            sticky <= 1'b0;
        end else begin
            state  <= state_d;
            e_res  <= e_res_d;
            fic    <= fic_d;
            g      <= g_d;
            wt     <= wt_d;
            zf     <= zf_d;
            ovf    <= ovf_d;
            unf    <= unf_d;
            sticky <= sticky_d;
            if (state == IDLE && start) begin
                ea_q <= ea;
                eb_q <= eb;
                op_q <= op;
            end
        end
    end

endmodule

// File: doc/fpm_exp_align.md
Name: fpm_exp_align

Overview:
- Parametrised successor to the fixed 8-bit exponent datapath of the FPU microoperation unit.
- Computes exponent differences, sums and differences for AF/SF, MF and DF, and normalisation exponent updates.
- Adds a self-timed alignment/normalisation sequencer with start/busy/done handshake. It issues per-cycle shift strobes to the mantissa datapath, replacing the externally stepped FIC counter.

Parameters:
EXP_W, 8, exponent width (two's complement)
CNT_W, 6, shift counter width; 2**CNT_W must be > MANT_BITS
MANT_BITS, 40, mantissa length; alignment distance at or above this sets g and skips shifting

Ports:
__clk  in  1  system clock, all state changes on rising edge
_0_f  in  1  asynchronous active-high reset (clear)
start  in  1  begin operation; sampled only in IDLE
op  in  2  00 add/sub align, 01 mul exponent add, 10 div exponent subtract, 11 normalise
ea  in  EXP_W  exponent of operand A (T side)
eb  in  EXP_W  exponent of operand B (C side)
mant_nz  in  1  mantissa non-zero (NORM)
mant_norm  in  1  mantissa normalised, bit0 != bit1 (NORM)
shifted_bit  in  1  bit shifted out by current right shift (sticky feature)
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
shr_t  out  1  shift T mantissa right one place this cycle
shr_c  out  1  shift C mantissa right one place this cycle
shl  out  1  shift mantissa left one place this cycle (NORM)
e_res  out  EXP_W  resulting exponent, low EXP_W bits
fic  out  CNT_W  remaining shift count
g  out  1  distance >= MANT_BITS
wt  out  1  result exponent taken from eb; T side was shifted
zf  out  1  zero result (NORM, mantissa zero)
ovf  out  1  exponent overflow
unf  out  1  exponent underflow
sticky  out  1  OR of bits shifted out during alignment

Behaviour:
- Reset: state IDLE; every output 0, including e_res and fic. Reset is effective mid-operation; no strobe after reset edge.
- States: IDLE, CALC, ALIGN, NORM, DONE.
- IDLE + start=1 at edge n:
  - latch ea, eb, op; go to CALC.
  - clear g/wt/zf/ovf/unf/sticky; busy=1 from n.
- start while busy: ignored.
- CALC arithmetic: sign-extend to EXP_W+2 bits.
- CALC, op=00:
  - diff = ea-eb; wt = diff<0; e_res = max(ea,eb).
  - |diff| >= MANT_BITS: g=1, go to DONE, no strobes.
  - diff=0: go to DONE.
  - otherwise: fic=|diff|, go to ALIGN.
- CALC, op=01/10:
  - r = ea+eb (01) or ea-eb (10); e_res = r[EXP_W-1:0].
  - ovf = r > 2**(EXP_W-1)-1; unf = r < -2**(EXP_W-1); go to DONE.
- CALC, op=11:
  - e_res=ea, fic=0, go to NORM.
- ALIGN:
  - each cycle, assert exactly one strobe: shr_t if wt, else shr_c.
  - fic decrements per strobe cycle; when fic reaches 1 at strobe, go to DONE next edge.
  - strobe count = |diff| exactly.
- NORM, evaluated each cycle:
  - mant_nz=0: zf=1, e_res=0, go to DONE.
  - mant_norm=1: go to DONE.
  - else: shl=1, e_res decrements, fic increments.
  - e_res would go below -2**(EXP_W-1): unf=1, DONE, no shl that cycle.
  - fic reaches MANT_BITS: zf=1, DONE.
- DONE: done=1 for one cycle; busy=0 in DONE; return to IDLE. Result flags and e_res hold until next accepted start.
- Strobes are combinational from state only, never from inputs, except NORM shl, which is gated by mant_nz/mant_norm.
- Latency: op 01/10: done in 2nd cycle after start edge. op 00: 2+|diff| cycles, or 2 if g or diff=0.

Optional Feature:
- FPM_EXP_STICKY_EN defined: in ALIGN, on each strobe cycle, sticky |= shifted_bit sampled at that edge; cleared on accepted start.
- Not defined: sticky is constant 0 and shifted_bit is unused.

Test Plan:
- ea=5, eb=2, op=00 -> shr_c high exactly 3 consecutive cycles, shr_t never; then done; e_res=5, wt=0, g=0, fic=0.
- ea=-10, eb=40, op=00 -> diff=-50 >= 40: g=1, wt=1, e_res=40, no strobes, done 2 cycles after start.
- ea=100, eb=50, op=01 -> e_res=8'h96, ovf=1. ea=-100, eb=50, op=10 -> e_res=8'h6A, unf=1.
- op=11, ea=3, mant_norm rising after 2 shl cycles -> shl count 2, e_res=1, done.
- op=11, ea=3, mant_nz=0 -> zf=1, e_res=0, no shl.
- ea=20, eb=0, op=00; assert _0_f after 4 strobes -> all outputs 0 immediately, state IDLE. A new start then runs normally.
- Sticky (with FPM_EXP_STICKY_EN): ea=0, eb=4, op=00, shifted_bit=1 only on 3rd strobe -> sticky=1 at done. Without the macro -> sticky=0.
